// File: rtl/cam_frame_writer_pkg.sv
// Shared geometry, state encoding and pixel type for the camera capture
// (write) side and the VGA read-side address translator.
package cam_frame_writer_pkg;

    localparam int ADDR_BITS    = 15;   // framebuffer address width
    localparam int IMAGE_SIZE_H = 160;  // stored columns
    localparam int IMAGE_SIZE_V = 120;  // stored rows
    localparam int DECIM_LOG2   = 2;    // keep every 4th pixel / 4th line
    localparam int SRC_BITS     = 12;   // source column/line counters (>= 640 px, 480 lines)

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        FRAME     = 2'd1,
        LINE      = 2'd2
    } cfw_state_t;

    typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/cam_frame_writer_if.sv
// Camera byte stream in, framebuffer write port out.
// master: the frame writer; slave: camera model / framebuffer side.
interface cam_frame_writer_if #(
    parameter int ADDR_BITS = cam_frame_writer_pkg::ADDR_BITS
) ();
    import cam_frame_writer_pkg::*;

    logic                 cam_vsync;
    logic                 cam_href;
    logic [7:0]           cam_data;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    rgb565_t              wr_data;
    logic                 frame_done;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output wr_en, wr_addr, wr_data, frame_done
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  wr_en, wr_addr, wr_data, frame_done
    );

endinterface

// File: rtl/cam_frame_writer_byte_pairer.sv
// cam_byte_pairer: joins consecutive camera bytes into RGB565 pixels.
// The first byte of a pair is held in hi_reg; the second byte completes the
// pixel combinationally. Whenever no byte is offered the phase returns to 0,
// so every line (and every resync) starts on a pixel boundary and an odd
// trailing byte is simply forgotten.
module cam_byte_pairer
    import cam_frame_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       pix_valid,
    output rgb565_t    pix_data
);

    logic       phase_reg;
    logic [7:0] hi_reg;

    // Byte phase toggle and first-byte latch; idle cycles realign the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= 1'b0;
            hi_reg    <= 8'd0;
        end else if (byte_valid) begin
            phase_reg <= ~phase_reg;
            if (!phase_reg) begin
                hi_reg <= byte_in;
            end
        end else begin
            phase_reg <= 1'b0;
        end
    end

    assign pix_valid = byte_valid & phase_reg;
    assign pix_data  = {hi_reg, byte_in};

endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: captures the OV7670 RGB565 byte stream, decimates it by
// 2**DECIM_LOG2 in both axes and writes the result into the 160x120
// framebuffer as linear addresses row*IMAGE_SIZE_H + col.
// Optional build macro: CAM_TEST_PATTERN_EN replaces the camera pixel with a
// coordinate pattern {dst_x[4:0], dst_y[5:0], dst_x[4:0]}; timing and
// addressing are identical in both builds.
module cam_frame_writer #(
    parameter int ADDR_BITS    = cam_frame_writer_pkg::ADDR_BITS,
    parameter int IMAGE_SIZE_H = cam_frame_writer_pkg::IMAGE_SIZE_H,
    parameter int IMAGE_SIZE_V = cam_frame_writer_pkg::IMAGE_SIZE_V,
    parameter int DECIM_LOG2   = cam_frame_writer_pkg::DECIM_LOG2
) (
    input  logic               clk,
    input  logic               rst_n,
    cam_frame_writer_if.master bus
);
    import cam_frame_writer_pkg::*;

    localparam logic [SRC_BITS-1:0]  SRC_ONE   = SRC_BITS'(1);
    localparam logic [SRC_BITS-1:0]  SRC_MAX   = '1;
    localparam logic [SRC_BITS-1:0]  DST_H_LIM = SRC_BITS'(IMAGE_SIZE_H);
    localparam logic [SRC_BITS-1:0]  DST_V_LIM = SRC_BITS'(IMAGE_SIZE_V);
    localparam logic [ADDR_BITS:0]   ROW_STEP  = (ADDR_BITS+1)'(IMAGE_SIZE_H);

    cfw_state_t           state_reg, state_next;
    logic                 vsync_prev_reg;
    logic [SRC_BITS-1:0]  src_x_reg, src_y_reg;
    logic [ADDR_BITS:0]   row_base_reg;

    logic                 wr_en_reg;
    logic [ADDR_BITS-1:0] wr_addr_reg;
    rgb565_t              wr_data_reg;
    logic                 frame_done_reg;

    logic                 vsync_rise, vsync_fall;
    logic                 capture_byte, line_end, frame_abort;
    logic                 pix_valid;
    rgb565_t              pix_data, pix_word;
    logic [SRC_BITS-1:0]  dst_x, dst_y;
    logic                 col_kept, line_kept, pix_keep;
    logic [ADDR_BITS:0]   addr_sum;
    logic                 addr_carry_unused;

    assign vsync_rise = bus.cam_vsync & ~vsync_prev_reg;
    assign vsync_fall = ~bus.cam_vsync & vsync_prev_reg;

    // State register and one-sample vsync history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SYNC_WAIT;
            vsync_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vsync_prev_reg <= bus.cam_vsync;
        end
    end

    // Next state plus per-cycle strobes; href is ignored while vsync is high.
    always_comb begin
        state_next   = state_reg;
        capture_byte = 1'b0;
        line_end     = 1'b0;
        frame_abort  = 1'b0;
        case (state_reg)
            SYNC_WAIT: begin
                if (vsync_fall) begin
                    state_next = FRAME;
                end
            end
            FRAME: begin
                if (bus.cam_vsync) begin
                    frame_abort = vsync_rise;
                end else if (bus.cam_href) begin
                    capture_byte = 1'b1;
                    state_next   = LINE;
                end
            end
            LINE: begin
                if (bus.cam_vsync) begin
                    frame_abort = vsync_rise;
                    state_next  = FRAME;
                end else if (bus.cam_href) begin
                    capture_byte = 1'b1;
                end else begin
                    line_end   = 1'b1;
                    state_next = FRAME;
                end
            end
            default: begin
                state_next = SYNC_WAIT;
            end
        endcase
    end

    cam_byte_pairer u_pairer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (capture_byte),
        .byte_in    (bus.cam_data),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data)
    );

    // Keep rule: aligned source coordinates that land inside the stored image.
    assign dst_x     = src_x_reg >> DECIM_LOG2;
    assign dst_y     = src_y_reg >> DECIM_LOG2;
    assign col_kept  = (src_x_reg[DECIM_LOG2-1:0] == '0) && (dst_x < DST_H_LIM);
    assign line_kept = (src_y_reg[DECIM_LOG2-1:0] == '0) && (dst_y < DST_V_LIM);
    assign pix_keep  = pix_valid & col_kept & line_kept;

    // row_base already holds row*IMAGE_SIZE_H, so the column is just added on.
    assign addr_sum          = row_base_reg + (ADDR_BITS+1)'(dst_x);
    assign addr_carry_unused = addr_sum[ADDR_BITS];

`ifdef CAM_TEST_PATTERN_EN
    rgb565_t pix_data_unused;
    assign pix_data_unused = pix_data;
    assign pix_word        = {dst_x[4:0], dst_y[5:0], dst_x[4:0]};
`else
    assign pix_word = pix_data;
`endif

    // Source position counters and row base accumulator; counters saturate so
    // an over-long line or frame can never wrap back into the visible area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_x_reg    <= '0;
            src_y_reg    <= '0;
            row_base_reg <= '0;
        end else if (frame_abort) begin
            src_x_reg    <= '0;
            src_y_reg    <= '0;
            row_base_reg <= '0;
        end else if (line_end) begin
            src_x_reg <= '0;
            if (src_y_reg != SRC_MAX) begin
                src_y_reg <= src_y_reg + SRC_ONE;
            end
            if (line_kept) begin
                row_base_reg <= row_base_reg + ROW_STEP;
            end
        end else if (pix_valid && (src_x_reg != SRC_MAX)) begin
            src_x_reg <= src_x_reg + SRC_ONE;
        end
    end

    // Registered write port; address and data hold between write strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            wr_en_reg      <= pix_keep;
            frame_done_reg <= frame_abort;
            if (pix_keep) begin
                wr_addr_reg <= addr_sum[ADDR_BITS-1:0];
                wr_data_reg <= pix_word;
            end
        end
    end

    assign bus.wr_en      = wr_en_reg;
    assign bus.wr_addr    = wr_addr_reg;
    assign bus.wr_data    = wr_data_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
